// File: rtl/quad_step_if.sv
// Bus between a quadrature step source and its decoder: phase inputs and clear in,
// position/direction/status out.
interface quad_step_if #(
  parameter int WIDTH = 4
);
  logic             phase_a;
  logic             phase_b;
  logic             clear;
  logic [WIDTH-1:0] count;
  logic             updown;
  logic             step;
  logic             err;

  modport master (
    output phase_a, phase_b, clear,
    input  count, updown, step, err
  );

  modport slave (
    input  phase_a, phase_b, clear,
    output count, updown, step, err
  );
endinterface

// File: rtl/quad_step_decoder.sv
// Quadrature step decoder: synchronises phase A/B, classifies Gray-code transitions
// and drives a modulo-2**WIDTH up/down position counter with a sticky error flag.
module quad_step_decoder #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  quad_step_if.slave  bus
);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  logic [SYNC_STAGES-1:0] a_sync_reg;
  logic [SYNC_STAGES-1:0] b_sync_reg;

  state_t           state_reg, state_next;
  logic [2:0]       flush_reg, flush_next;
  logic [1:0]       prev_reg, prev_next;
  logic [WIDTH-1:0] count_reg, count_next;
  logic             updown_reg, updown_next;
  logic             step_reg, step_next;
  logic             err_reg, err_next;

  logic [1:0] s;
  logic [1:0] s_incoming;

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          a_sync_reg[gi] <= 1'b0;
          b_sync_reg[gi] <= 1'b0;
        end else if (gi == 0) begin
          a_sync_reg[gi] <= bus.phase_a;
          b_sync_reg[gi] <= bus.phase_b;
        end else begin
          a_sync_reg[gi] <= a_sync_reg[gi-1];
          b_sync_reg[gi] <= b_sync_reg[gi-1];
        end
      end
    end
  endgenerate

  assign s = {a_sync_reg[SYNC_STAGES-1], b_sync_reg[SYNC_STAGES-1]};
  // The value s takes after this edge; on the last flush cycle the chain output
  // still holds reset zeros, so the reference is taken one stage earlier.
  assign s_incoming = {a_sync_reg[SYNC_STAGES-2], b_sync_reg[SYNC_STAGES-2]};

  // Forward Gray sequence 00->01->11->10->00
  function automatic logic [1:0] gray_fwd(input logic [1:0] p);
    case (p)
      2'b00:   gray_fwd = 2'b01;
      2'b01:   gray_fwd = 2'b11;
      2'b11:   gray_fwd = 2'b10;
      default: gray_fwd = 2'b00;
    endcase
  endfunction

  always_comb begin
    state_next  = state_reg;
    flush_next  = flush_reg;
    prev_next   = prev_reg;
    count_next  = count_reg;
    updown_next = updown_reg;
    step_next   = 1'b0;
    err_next    = err_reg;

    case (state_reg)
      ST_INIT: begin
        flush_next = flush_reg + 3'd1;
        if (flush_reg == 3'(SYNC_STAGES - 1)) begin
          prev_next  = s_incoming;
          flush_next = '0;
          state_next = ST_RUN;
        end
      end
      default: begin
        prev_next = s;
        if (bus.clear) begin
          count_next = '0;
          err_next   = 1'b0;
        end else if (s == prev_reg) begin
          count_next = count_reg;
        end else if (s == gray_fwd(prev_reg)) begin
          count_next  = count_reg + 1'b1;
          updown_next = 1'b1;
          step_next   = 1'b1;
        end else if (gray_fwd(s) == prev_reg) begin
          count_next  = count_reg - 1'b1;
          updown_next = 1'b0;
          step_next   = 1'b1;
        end else begin
          err_next = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= ST_INIT;
      flush_reg  <= '0;
      prev_reg   <= 2'b00;
      count_reg  <= '0;
      updown_reg <= 1'b1;
      step_reg   <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      flush_reg  <= flush_next;
      prev_reg   <= prev_next;
      count_reg  <= count_next;
      updown_reg <= updown_next;
      step_reg   <= step_next;
      err_reg    <= err_next;
    end
  end

  assign bus.count  = count_reg;
  assign bus.updown = updown_reg;
  assign bus.step   = step_reg;
  assign bus.err    = err_reg;

endmodule
